fir_coef_loader: RTL and testbench

Upstream configuration stage for the `fir` filter: accepts a coefficient frame one word per cycle over a valid/ready stream and stages it into a shadow bank. Once the frame is complete and correct, it commits the frame atomically to the active bank that drives the filter's `in_weights`. The commit happens only on a cycle with no sample transfer, so a sample is never filtered with a mix of old and new weights. Frames with the wrong length are discarded and flagged.

---
 rtl/fir_coef_loader.sv | 186 ++++++++++++++++++
 tb/tb_fir_coef_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_loader.sv
// -----------------------------------------------------------------------------
// fir_coef_loader
//
// Upstream configuration stage for the fir filter. Coefficient words arrive one
// per cycle on a valid/ready stream (tap 0 first). They are collected in a
// shadow bank. When a frame of the right length closes with cfg_last, the frame
// waits for a cycle with no sample transfer. On that cycle it is copied
// atomically into the active bank that drives the filter's in_weights. A sample
// therefore never sees a mix of old and new weights. A frame of the wrong length
// is dropped, frame_err pulses, and the active bank is left alone.
//
// Optional feature: define FIR_COEF_SYMMETRIC_EN to load linear-phase filters
// with ceil(TAPS/2) words. On commit, weights[i] and weights[TAPS-1-i] both take
// shadow[i].
//
// Parameters:
//   TAPS          number of filter coefficients (>= 2)
//   WIDTH         coefficient word width
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   cfg_valid     coefficient word present
//   cfg_ready     loader can accept a word (registered, state-derived)
//   cfg_data      coefficient word
//   cfg_last      final word of a frame
//   sample_valid  filter in_valid strobe; a commit waits while it is high
//   weights       active bank [0:TAPS-1], resets to an impulse
//   coef_update   one-cycle pulse after the active bank changed
//   frame_err     one-cycle pulse when a frame is dropped
//   busy          high while loading or waiting to commit
// -----------------------------------------------------------------------------
module fir_coef_loader #(
   parameter int TAPS  = 8,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_data,
   input  logic             cfg_last,
   input  logic             sample_valid,
   output logic [WIDTH-1:0] weights [0:TAPS-1],
   output logic             coef_update,
   output logic             frame_err,
   output logic             busy
);

`ifdef FIR_COEF_SYMMETRIC_EN
   localparam int FRAME_LEN = (TAPS + 1) / 2;
`else
   localparam int FRAME_LEN = TAPS;
`endif
   localparam int            IW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_PENDING = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [IW-1:0]    idx_r;
   logic [IW-1:0]    idx_s;
   logic             accept_s;
   logic             shadow_we_s;
   logic             commit_s;
   logic             err_s;
   logic [WIDTH-1:0] shadow_r [0:FRAME_LEN-1];
   logic [WIDTH-1:0] bank_s   [0:TAPS-1];
   logic [WIDTH-1:0] weights_r [0:TAPS-1];
   logic             cfg_ready_r;
   logic             coef_update_r;
   logic             frame_err_r;
   logic             busy_r;

   // Next-state, index and strobe decode for the frame FSM
   always_comb begin
      state_s     = state_r;
      idx_s       = idx_r;
      shadow_we_s = 1'b0;
      commit_s    = 1'b0;
      err_s       = 1'b0;
      accept_s    = cfg_valid && cfg_ready_r;
      case (state_r)
         // IDLE and LOAD share one rule because the index is 0 in IDLE.
         // The first word of a frame is therefore just the index-0 case.
         ST_IDLE, ST_LOAD: begin
            if (accept_s) begin
               shadow_we_s = 1'b1;
               if (cfg_last && (idx_r == LAST_IDX)) begin
                  state_s = ST_PENDING;
                  idx_s   = {IW{1'b0}};
               end else if (cfg_last || (idx_r == LAST_IDX)) begin
                  // Short frame, or long frame that missed cfg_last.
                  err_s   = 1'b1;
                  state_s = ST_IDLE;
                  idx_s   = {IW{1'b0}};
               end else begin
                  state_s = ST_LOAD;
                  idx_s   = idx_r + IW'(1);
               end
            end else begin
               state_s = state_r;
               idx_s   = idx_r;
            end
         end
         ST_PENDING: begin
            if (!sample_valid) begin
               commit_s = 1'b1;
               state_s  = ST_IDLE;
            end else begin
               state_s  = ST_PENDING;
            end
         end
         default: begin
            state_s = ST_IDLE;
            idx_s   = {IW{1'b0}};
         end
      endcase
   end

   // Commit image of the shadow bank, mirrored when only half is loaded
   for (genvar g = 0; g < TAPS; g++) begin : g_bank
      localparam int SRC = (g < FRAME_LEN) ? g : (TAPS - 1 - g);
      assign bank_s[g] = shadow_r[SRC];
   end

   // FSM state, index and the registered handshake/status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= ST_IDLE;
         idx_r         <= {IW{1'b0}};
         cfg_ready_r   <= 1'b1;
         coef_update_r <= 1'b0;
         frame_err_r   <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         state_r       <= state_s;
         idx_r         <= idx_s;
         // Ready and busy come from the next state only, so they are never
         // a combinational function of cfg_valid.
         cfg_ready_r   <= (state_s != ST_PENDING);
         busy_r        <= (state_s != ST_IDLE);
         coef_update_r <= commit_s;
         frame_err_r   <= err_s;
      end
   end

   // Shadow bank capture of accepted words
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FRAME_LEN; i++) begin
            shadow_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         for (int i = 0; i < FRAME_LEN; i++) begin
            if (shadow_we_s && (idx_r == IW'(i))) begin
               shadow_r[i] <= cfg_data;
            end
         end
      end
   end

   // Active bank: impulse after reset, replaced whole on a commit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < TAPS; i++) begin
            weights_r[i] <= (i == 0) ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
         end
      end else if (commit_s) begin
         for (int i = 0; i < TAPS; i++) begin
            weights_r[i] <= bank_s[i];
         end
      end
   end

   assign weights     = weights_r;
   assign cfg_ready   = cfg_ready_r;
   assign coef_update = coef_update_r;
   assign frame_err   = frame_err_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_fir_coef_loader.sv
// -----------------------------------------------------------------------------
// tb_fir_coef_loader
//
// Self-checking bench for fir_coef_loader (TAPS=8, WIDTH=16).
// A frame-level model collects words into an array and counts them. It marks
// a frame pending once the length is right, and commits it on the first
// sampled edge with sample_valid low. Every falling edge compares all DUT
// outputs against that model. Directed stimulus also checks hand-computed
// literal banks. The symmetric scenarios run when FIR_COEF_SYMMETRIC_EN is
// defined.
// -----------------------------------------------------------------------------
module tb_fir_coef_loader;
   localparam int TAPS  = 8;
   localparam int WIDTH = 16;
`ifdef FIR_COEF_SYMMETRIC_EN
   localparam int FLEN = (TAPS + 1) / 2;
`else
   localparam int FLEN = TAPS;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [WIDTH-1:0] cfg_data = 16'd0;
   logic             cfg_last = 1'b0;
   logic             sample_valid = 1'b0;
   logic [WIDTH-1:0] weights [0:TAPS-1];
   logic             coef_update;
   logic             frame_err;
   logic             busy;

   int checks   = 0;
   int failures = 0;

   fir_coef_loader #(.TAPS(TAPS), .WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_data     (cfg_data),
      .cfg_last     (cfg_last),
      .sample_valid (sample_valid),
      .weights      (weights),
      .coef_update  (coef_update),
      .frame_err    (frame_err),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   function automatic logic [127:0] pack8(input logic [15:0] w [0:7]);
      logic [127:0] r;
      r = 128'd0;
      for (int i = 0; i < 8; i++) r[127-16*i -: 16] = w[i];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] m_w  [0:7];
   logic [15:0] m_fr [0:7];
   int          m_n;
   bit          m_pend;
   bit          m_upd;
   bit          m_err;

   task automatic m_reset();
      for (int i = 0; i < 8; i++) begin
         m_w[i]  = (i == 0) ? 16'd1 : 16'd0;
         m_fr[i] = 16'd0;
      end
      m_n = 0; m_pend = 1'b0; m_upd = 1'b0; m_err = 1'b0;
   endtask

   task automatic m_step();
      logic [2:0] s;
      m_upd = 1'b0;
      m_err = 1'b0;
      if (m_pend) begin
         if (!sample_valid) begin
            for (int i = 0; i < 8; i++) begin
               s = 3'((i < FLEN) ? i : (TAPS - 1 - i));
               m_w[3'(i)] = m_fr[s];
            end
            m_pend = 1'b0; m_n = 0; m_upd = 1'b1;
         end
      end else if (cfg_valid) begin
         m_fr[m_n[2:0]] = cfg_data;
         m_n = m_n + 1;
         if (cfg_last && m_n == FLEN) m_pend = 1'b1;
         else if (cfg_last || m_n == FLEN) begin
            m_err = 1'b1; m_n = 0;
         end
      end
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) m_reset();
         else m_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         chk("model_weights", pack8(weights), pack8(m_w));
         chk("model_cfg_ready", {127'd0, cfg_ready}, {127'd0, !m_pend});
         chk("model_coef_update", {127'd0, coef_update}, {127'd0, m_upd});
         chk("model_frame_err", {127'd0, frame_err}, {127'd0, m_err});
         chk("model_busy", {127'd0, busy}, {127'd0, (m_pend || m_n != 0)});
      end
   end

   // ---------------- stimulus ----------------
   task automatic send_word(input int data, input bit last);
      chk("ready_before_word", {127'd0, cfg_ready}, 128'd1);
      cfg_valid = 1'b1;
      cfg_data  = 16'(data);
      cfg_last  = last;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
   endtask

   task automatic send_frame(input int n, input int lastpos, input int base,
                             input int step, input bit gap);
      for (int k = 0; k < n; k++) begin
         send_word(base + step * k, k == lastpos);
         if (gap && k != n - 1) begin
            @(posedge clk); #1;
         end
      end
   endtask

   localparam logic [127:0] IMPULSE = {16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_weights", pack8(weights), IMPULSE);
      chk("reset_ready", {127'd0, cfg_ready}, 128'd1);
      chk("reset_busy", {127'd0, busy}, 128'd0);
      chk("reset_update", {127'd0, coef_update}, 128'd0);
      #6 rst = 1'b1;
      @(posedge clk); #1;

`ifdef FIR_COEF_SYMMETRIC_EN
      send_frame(4, 3, 2, 2, 1'b0);
      @(posedge clk); #1;
      chk("sym_weights", pack8(weights),
          {16'd2, 16'd4, 16'd6, 16'd8, 16'd8, 16'd6, 16'd4, 16'd2});
      chk("sym_update", {127'd0, coef_update}, 128'd1);
      @(posedge clk); #1;
      send_frame(5, 4, 50, 1, 1'b0);
      chk("sym_long_err", {127'd0, frame_err}, 128'd1);
      chk("sym_long_weights", pack8(weights),
          {16'd2, 16'd4, 16'd6, 16'd8, 16'd8, 16'd6, 16'd4, 16'd2});
`else
      // Frame A: 1,3,...,15 with the sample strobe idle
      send_frame(8, 7, 1, 2, 1'b0);
      chk("a_before_commit", pack8(weights), IMPULSE);
      @(posedge clk); #1;
      chk("a_weights", pack8(weights),
          {16'd1, 16'd3, 16'd5, 16'd7, 16'd9, 16'd11, 16'd13, 16'd15});
      chk("a_update", {127'd0, coef_update}, 128'd1);
      @(posedge clk); #1;
      chk("a_update_drop", {127'd0, coef_update}, 128'd0);

      // Frame B: commit held off by 5 cycles of sample traffic
      send_frame(8, 7, 10, 10, 1'b0);
      sample_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("b_hold_ready", {127'd0, cfg_ready}, 128'd0);
         chk("b_hold_weights", pack8(weights),
             {16'd1, 16'd3, 16'd5, 16'd7, 16'd9, 16'd11, 16'd13, 16'd15});
      end
      sample_valid = 1'b0;
      @(posedge clk); #1;
      chk("b_weights", pack8(weights),
          {16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80});
      chk("b_update", {127'd0, coef_update}, 128'd1);

      // Short frame: cfg_last on word 3
      send_frame(3, 2, 200, 1, 1'b0);
      chk("short_err", {127'd0, frame_err}, 128'd1);
      @(posedge clk); #1;
      chk("short_err_drop", {127'd0, frame_err}, 128'd0);

      // Long frame: 8th word without cfg_last
      send_frame(8, -1, 300, 1, 1'b0);
      chk("long_err", {127'd0, frame_err}, 128'd1);
      chk("long_busy", {127'd0, busy}, 128'd0);
      chk("long_weights", pack8(weights),
          {16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80});

      // Gapped frame while samples flow; sample_valid is ignored until pending
      sample_valid = 1'b1;
      send_frame(8, 7, 5, 5, 1'b1);
      sample_valid = 1'b0;
      @(posedge clk); #1;
      chk("gap_weights", pack8(weights),
          {16'd5, 16'd10, 16'd15, 16'd20, 16'd25, 16'd30, 16'd35, 16'd40});

      // Reset after 4 words
      send_frame(4, -1, 7, 1, 1'b0);
      #3 rst = 1'b0;
      #1;
      chk("midrst_weights", pack8(weights), IMPULSE);
      chk("midrst_ready", {127'd0, cfg_ready}, 128'd1);
      chk("midrst_busy", {127'd0, busy}, 128'd0);
      #7 rst = 1'b1;
      @(posedge clk); #1;
      send_frame(8, 7, 3, 3, 1'b0);
      @(posedge clk); #1;
      chk("fresh_weights", pack8(weights),
          {16'd3, 16'd6, 16'd9, 16'd12, 16'd15, 16'd18, 16'd21, 16'd24});
`endif
      repeat (2) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
